// File: rtl/midi_pkg.sv
// midi_pkg -- constants and helpers shared by the MIDI receive path.
//   ST_*          FSM state encodings used by midi_rx
//   STATUS_MASK   bit that marks a MIDI status byte
//   REALTIME_MIN  lowest system-realtime status value
//   DEFAULT_BAUD  MIDI line rate in bit/s
//   bit_cycles()  clock cycles per serial bit for a given clock and baud
package midi_pkg;

  localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;

  localparam logic [7:0] STATUS_MASK  = 8'h80;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;
  localparam int         DEFAULT_BAUD = 31_250;

  function automatic int bit_cycles(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/midi_rx_activity_stretch.sv
// activity_stretch -- retriggerable hold timer for activity LEDs.
//   clk      system clock
//   rst      asynchronous active-high reset
//   trigger  reload the hold counter to HOLD this cycle
//   active   high while the hold counter is nonzero (registered)
// A reload always wins over the decrement. The counter saturates at zero.
module activity_stretch #(
  parameter int HOLD = 600_000
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic active
);

  localparam int            CW       = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_VAL = CW'(HOLD);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] count;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      active <= 1'b0;
    end else if (trigger) begin
      count  <= HOLD_VAL;
      active <= (HOLD_VAL != '0);
    end else if (count != '0) begin
      count  <= count - ONE;
      // active mirrors the post-edge count, so it drops on the same edge
      // that the counter reaches zero.
      active <= (count != ONE);
    end
  end

endmodule

// File: rtl/midi_rx.sv
// midi_rx -- single-port MIDI serial receiver (8N1, LSB first).
//   clk          system clock
//   rst          asynchronous active-high reset
//   rx           raw MIDI line, idle high, asynchronous to clk
//   data         last good byte, held until the next good byte
//   valid        one-cycle strobe: data is new
//   is_status    qualifies valid: data[7] set
//   is_realtime  qualifies valid: data >= 8'hF8
//   ferr         one-cycle strobe: stop bit sampled low
//   activity     stretched activity flag for the port LED
// Every line sample is taken at the centre of a bit, timed from the first
// low synchronized sample seen in IDLE.
module midi_rx
  import midi_pkg::*;
#(
  parameter int CLOCK    = 12_000_000,
  parameter int BAUD     = DEFAULT_BAUD,
  parameter int ACT_HOLD = 600_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       is_status,
  output logic       is_realtime,
  output logic       ferr,
  output logic       activity
);

  localparam int            BIT       = bit_cycles(CLOCK, BAUD);
  localparam int            HALF      = BIT / 2;
  localparam int            TW        = (BIT > 1) ? $clog2(BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);

  logic [1:0]    sync;
  logic          rx_s;
  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          start_accept;

  // Synchronizer resets to the idle line level so reset never looks like
  // a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};
  end

  assign rx_s = sync[1];

  // Start bit still low at its centre: a real frame begins.
  assign start_accept = (state == ST_START) && (timer == HALF_LAST) && !rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_WAIT_IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data        <= '0;
      valid       <= 1'b0;
      is_status   <= 1'b0;
      is_realtime <= 1'b0;
      ferr        <= 1'b0;
    end else begin
      valid <= 1'b0;
      ferr  <= 1'b0;
      case (state)
        // Require one full bit time of continuous high before trusting the
        // line, so a reset or break mid-frame cannot misframe.
        ST_WAIT_IDLE: begin
          if (!rx_s) begin
            timer <= '0;
          end else if (timer == BIT_LAST) begin
            timer <= '0;
            state <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_IDLE: begin
          if (!rx_s) begin
            timer <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (timer == HALF_LAST) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (timer == BIT_LAST) begin
            timer   <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            if (rx_s) begin
              valid       <= 1'b1;
              data        <= shift;
              is_status   <= (shift & STATUS_MASK) != 8'h00;
              is_realtime <= (shift >= REALTIME_MIN);
              state       <= ST_IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= ST_WAIT_IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          timer <= '0;
          state <= ST_WAIT_IDLE;
        end
      endcase
    end
  end

  activity_stretch #(
    .HOLD(ACT_HOLD)
  ) u_activity (
    .clk    (clk),
    .rst    (rst),
    .trigger(start_accept),
    .active (activity)
  );

endmodule

// File: tb/tb_midi_rx.sv
// tb_midi_rx -- scoreboard bench for midi_rx.
// Each frame sent pushes its expected strobe (kind, data, flags, cycle) to a
// queue; a negedge monitor pops and compares whenever valid or ferr fires.
module tb_midi_rx;

  localparam int BIT      = 384;
  localparam int ACT_HOLD = 5000;
  // Start-edge drive cycle to strobe cycle: 2 synchronizer cycles + 3649.
  localparam int STROBE_LAT = 2 + 3649;

  typedef struct {
    logic       is_ferr;
    logic [7:0] data;
    logic       st;
    logic       rt;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       is_status;
  logic       is_realtime;
  logic       ferr;
  logic       activity;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb_q[$];

  logic [7:0] lg_data = 8'h00;
  logic       lg_st   = 1'b0;
  logic       lg_rt   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  midi_rx #(
    .CLOCK   (12_000_000),
    .BAUD    (31_250),
    .ACT_HOLD(ACT_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .is_status  (is_status),
    .is_realtime(is_realtime),
    .ferr       (ferr),
    .activity   (activity)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait n clock edges, then move 1 time unit past the edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    idle(BIT);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    exp_t e;
    e.at = cyc + STROBE_LAT;
    if (stop_bit) begin
      e.is_ferr = 1'b0;
      e.data    = b;
      e.st      = b[7];
      e.rt      = (b >= 8'hF8);
      lg_data   = e.data;
      lg_st     = e.st;
      lg_rt     = e.rt;
    end else begin
      e.is_ferr = 1'b1;
      e.data    = lg_data;
      e.st      = lg_st;
      e.rt      = lg_rt;
    end
    sb_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (valid || ferr)) begin
      check("single_strobe", 32'(valid && ferr), 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 32'({valid, ferr}), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("strobe_kind_ferr", 32'(ferr), 32'(e.is_ferr));
        check("strobe_cycle", 32'(cyc), 32'(e.at));
        check("data", 32'(data), 32'(e.data));
        check("is_status", 32'(is_status), 32'(e.st));
        check("is_realtime", 32'(is_realtime), 32'(e.rt));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int s;
    int lows;
    logic seen;

    // Reset state
    rx  = 1'b1;
    rst = 1'b1;
    idle(3);
    check("rst_data", 32'(data), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_is_status", 32'(is_status), 32'd0);
    check("rst_is_realtime", 32'(is_realtime), 32'd0);
    check("rst_activity", 32'(activity), 32'd0);
    rst = 1'b0;
    idle(400);

    // 1: status byte, activity rises just after start acceptance
    s = cyc;
    fork
      send_byte(8'h90, 1'b1);
      begin
        at_cycle(s + 192);
        check("t1_act_before", 32'(activity), 32'd0);
        at_cycle(s + 196);
        check("t1_act_after", 32'(activity), 32'd1);
      end
    join

    // 2: realtime byte, then let activity expire
    send_byte(8'hF8, 1'b1);
    idle(ACT_HOLD + 400);
    check("t2_act_expired", 32'(activity), 32'd0);

    // 3: 100-cycle glitch is rejected without activity
    rx = 1'b0;
    idle(100);
    rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      seen = seen | activity;
    end
    idle(1);
    check("t3_glitch_act", 32'(seen), 32'd0);
    send_byte(8'h45, 1'b1);

    // 4: framing error, line held low, short high then low must not frame
    send_byte(8'h00, 1'b0);
    idle(2000);
    rx = 1'b1;
    idle(200);
    rx = 1'b0;
    idle(300);
    rx = 1'b1;
    idle(400);
    check("t4_data_kept", 32'(data), 32'h45);
    send_byte(8'h3C, 1'b1);

    // 5: back-to-back frames, activity held then falls exactly on time
    s = cyc;
    fork
      begin
        send_byte(8'h3C, 1'b1);
        send_byte(8'h7F, 1'b1);
      end
      begin
        lows = 0;
        at_cycle(s + 196);
        while (cyc < s + BIT * 10 + 194 + ACT_HOLD) begin
          @(negedge clk);
          if (!activity) lows++;
        end
        check("t5_act_held", 32'(lows), 32'd0);
        @(negedge clk);
        check("t5_act_fall", 32'(activity), 32'd0);
      end
    join
    idle(1);

    // 6: reset mid-frame, released while the line is low
    rx = 1'b0;
    idle(BIT);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx = 1'b0;
    idle(100);
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_data", 32'(data), 32'd0);
    check("t6_rst_valid", 32'(valid), 32'd0);
    check("t6_rst_ferr", 32'(ferr), 32'd0);
    check("t6_rst_is_status", 32'(is_status), 32'd0);
    check("t6_rst_is_realtime", 32'(is_realtime), 32'd0);
    check("t6_rst_activity", 32'(activity), 32'd0);
    lg_data = 8'h00;
    lg_st   = 1'b0;
    lg_rt   = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(500);
    rx = 1'b1;
    idle(400);
    send_byte(8'hF0, 1'b1);

    idle(100);
    check("pending_strobes", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_rx.md
Name: midi_rx

Overview:
Per-port MIDI serial receiver, one instance per physical input in the MIDI controller. Each instance sits directly upstream of the routing logic.
- Converts the raw 31250-baud input line into byte strobes, with status/realtime classification and framing-error reporting.
- Produces a stretched per-port activity flag that feeds the shift-register activity LED driver.

Parameters:
CLOCK, 12_000_000, system clock frequency in Hz
BAUD, 31_250, MIDI bit rate; BIT = CLOCK/BAUD = 384 cycles, HALF = BIT/2 = 192
ACT_HOLD, 600_000, activity flag hold time in clk cycles (50 ms at 12 MHz)

Ports:
clk  input  1  system clock; the only clock
rst  input  1  reset, asynchronous, active-high
rx  input  1  raw MIDI line from opto; idle high, asynchronous to clk
data  output  8  last received byte; held until the next valid byte
valid  output  1  one-cycle strobe; data is new
is_status  output  1  qualifies valid: data[7]==1
is_realtime  output  1  qualifies valid: data>=8'hF8
ferr  output  1  one-cycle strobe; stop bit sampled low
activity  output  1  high while the hold counter is nonzero

Behaviour:
- Reset (async) clears data=0, valid=0, is_status=0, is_realtime=0, ferr=0, activity=0, hold counter=0, and state=WAIT_IDLE. The two synchronizer flops reset to 1.
- rx passes through a 2-FF synchronizer to give rx_s, with 2 cycles of latency. All logic uses rx_s only.
- Let t0 be the first cycle with rx_s==0 while in IDLE.
- WAIT_IDLE:
  - A counter counts consecutive cycles of rx_s==1 and clears on any 0.
  - At BIT consecutive highs the state moves to IDLE.
  - This prevents misframing after reset mid-frame or after a break.
- IDLE: rx_s==0 moves to START and clears the bit-timer.
- START:
  - Sample at t0+HALF.
  - If the sample is 1, it was a glitch: go to IDLE with no strobe and no activity.
  - If the sample is 0, reload the hold counter to ACT_HOLD, set bit index 0, and go to DATA.
- DATA:
  - Sample bit i at t0+HALF+BIT*(i+1), for i=0..7, LSB first, into a shift register.
  - After bit 7, go to STOP.
- STOP: sample at t0+HALF+9*BIT = t0+3648.
  - If the sample is 1: at t0+3649, pulse valid for 1 cycle, update data, and register is_status/is_realtime (held with data). Then go to IDLE.
  - If the sample is 0: at t0+3649, pulse ferr for 1 cycle. data, is_status and is_realtime are unchanged. Then go to WAIT_IDLE.
- valid and ferr are never high in the same cycle.
- Back-to-back frames are accepted: a start bit immediately after the stop sample is detected once IDLE is re-entered. The receiver is back in IDLE by t0+3649, before the next start edge at t0+3840.
- Activity hold counter:
  - Reload to ACT_HOLD on each accepted start bit.
  - Otherwise decrement while nonzero; saturate at 0.
  - activity = (counter != 0), registered.
  - A reload and a decrement in the same cycle resolve to the reload.
- The bit-timer is wide enough for BIT-1. The hold counter is $clog2(ACT_HOLD+1) bits. Neither counter wraps.
- No byte-level buffering; the consumer must take data on valid.

Decomposition:
- Shared package midi_pkg:
  - state encoding (WAIT_IDLE, IDLE, START, DATA, STOP)
  - MIDI constants: STATUS_MASK 8'h80, REALTIME_MIN 8'hF8, DEFAULT_BAUD 31250
  - helper function computing BIT from CLOCK/BAUD
- Sub-module activity_stretch(clk, rst, trigger, active, parameter HOLD) holds the hold counter. It is reusable for output-port activity as well.

Test Plan:
1. Send 8'h90 at 31250 baud after >=384 idle cycles. Require exactly one valid at t0+3649 with data=8'h90, is_status=1, is_realtime=0, ferr=0, activity high from t0+HALF.
2. Send 8'hF8. Require valid with data=8'hF8, is_status=1, is_realtime=1.
3. Drive a 100-cycle low glitch on an idle line. Require no valid, no ferr, activity stays 0, and the next real byte 8'h45 is received correctly.
4. Send 8'h00 with stop bit low and hold the line low for 2000 cycles. Require ferr for 1 cycle, no valid, data unchanged, and no further strobes until 384 high cycles pass. A following 8'h3C is then received.
5. Send 8'h3C then 8'h7F with no gap. Require two valid strobes 3840 cycles apart with the correct data. Activity stays high through both and falls exactly ACT_HOLD cycles after the second start acceptance.
6. Assert rst mid-frame during a byte and release while rx is low. Require all outputs 0 immediately and no valid for the partial frame. The next byte is received correctly after the line has been high for 384 cycles.
